// File: rtl/e_muldiv_if.sv
// e_muldiv_if: bus between the E stage and the multiply/divide unit.
// Carries the issue request, operands, HI/LO read-back and the stall
// information for the hazard unit.
// Optional feature macro: MDU_CANCEL_EN adds the cancel request.
interface e_muldiv_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
`ifdef MDU_CANCEL_EN
  logic        cancel;
`endif
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

`ifdef MDU_CANCEL_EN
  // E stage / hazard unit side
  modport master (output start, op, a, b, cancel,
                  input  busy, md_stall, hi, lo);
  // Multiply/divide unit side
  modport slave  (input  start, op, a, b, cancel,
                  output busy, md_stall, hi, lo);
`else
  // E stage / hazard unit side
  modport master (output start, op, a, b,
                  input  busy, md_stall, hi, lo);
  // Multiply/divide unit side
  modport slave  (input  start, op, a, b,
                  output busy, md_stall, hi, lo);
`endif
endinterface

// File: rtl/e_muldiv.sv
// e_muldiv: E-stage multiply/divide unit holding the HI/LO register pair.
// MULT/MULTU/DIV/DIVU run for a fixed number of busy cycles and commit
// their result at the end. MTHI/MTLO write in a single cycle.
// Optional feature macro: MDU_CANCEL_EN (abort an in-flight operation).
module e_muldiv #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic        clk,
  input logic        reset,
  e_muldiv_if.slave  bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic               busy_r;
  logic [31:0]        hi_r;
  logic [31:0]        lo_r;
  logic [31:0]        hi_p;
  logic [31:0]        lo_p;
  logic               pend_valid;

  logic               cancel_req;
  logic               is_md_op;

  logic [63:0]        a_sx;
  logic [63:0]        b_sx;
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;

  logic               a_neg;
  logic               b_neg;
  logic [31:0]        a_mag;
  logic [31:0]        b_mag;
  logic [31:0]        div_s_den;
  logic [31:0]        q_mag;
  logic [31:0]        r_mag;
  logic [31:0]        q_s;
  logic [31:0]        r_s;
  logic [31:0]        div_u_den;
  logic [31:0]        q_u;
  logic [31:0]        r_u;

  logic [31:0]        res_hi;
  logic [31:0]        res_lo;
  logic               res_valid;
  logic [CNT_W-1:0]   res_cycles;

`ifdef MDU_CANCEL_EN
  assign cancel_req = bus.cancel;
`else
  assign cancel_req = 1'b0;
`endif

  assign is_md_op = (bus.op[2] == 1'b0);

  // Full-width products; operands are extended explicitly so the
  // 64-bit product needs no implicit width conversion.
  always_comb begin
    a_sx   = {{32{bus.a[31]}}, bus.a};
    b_sx   = {{32{bus.b[31]}}, bus.b};
    prod_s = a_sx * b_sx;
    prod_u = {32'h0, bus.a} * {32'h0, bus.b};
  end

  // Division on magnitudes so that 0x80000000 / -1 never overflows the
  // divider: the magnitude quotient is 0x80000000 with positive sign,
  // which is exactly the architected result. A zero divisor is swapped
  // for 1 only to keep the divider well-defined; its result is dropped.
  always_comb begin
    a_neg     = bus.a[31];
    b_neg     = bus.b[31];
    a_mag     = a_neg ? (~bus.a + 32'd1) : bus.a;
    b_mag     = b_neg ? (~bus.b + 32'd1) : bus.b;
    div_s_den = (bus.b == 32'd0) ? 32'd1 : b_mag;
    q_mag     = a_mag / div_s_den;
    r_mag     = a_mag % div_s_den;
    q_s       = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    r_s       = a_neg ? (~r_mag + 32'd1) : r_mag;
    div_u_den = (bus.b == 32'd0) ? 32'd1 : bus.b;
    q_u       = bus.a / div_u_den;
    r_u       = bus.a % div_u_den;
  end

  // Select the pending result, its validity and the busy length by opcode.
  always_comb begin
    res_hi     = 32'd0;
    res_lo     = 32'd0;
    res_valid  = 1'b0;
    res_cycles = '0;
    case (bus.op)
      OP_MULT: begin
        res_hi     = prod_s[63:32];
        res_lo     = prod_s[31:0];
        res_valid  = 1'b1;
        res_cycles = CNT_W'(MULT_CYCLES);
      end
      OP_MULTU: begin
        res_hi     = prod_u[63:32];
        res_lo     = prod_u[31:0];
        res_valid  = 1'b1;
        res_cycles = CNT_W'(MULT_CYCLES);
      end
      OP_DIV: begin
        res_hi     = r_s;
        res_lo     = q_s;
        res_valid  = (bus.b != 32'd0);
        res_cycles = CNT_W'(DIV_CYCLES);
      end
      OP_DIVU: begin
        res_hi     = r_u;
        res_lo     = q_u;
        res_valid  = (bus.b != 32'd0);
        res_cycles = CNT_W'(DIV_CYCLES);
      end
      default: begin
        res_hi     = 32'd0;
        res_lo     = 32'd0;
        res_valid  = 1'b0;
        res_cycles = '0;
      end
    endcase
  end

  // Control FSM: accept ops in IDLE, count down in BUSY, commit at zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      busy_r     <= 1'b0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
      hi_p       <= 32'd0;
      lo_p       <= 32'd0;
      pend_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cancel_req) begin
            state <= IDLE;
          end else if (bus.start) begin
            if (is_md_op) begin
              hi_p       <= res_hi;
              lo_p       <= res_lo;
              pend_valid <= res_valid;
              count      <= res_cycles;
              busy_r     <= 1'b1;
              state      <= BUSY;
            end else if (bus.op == OP_MTHI) begin
              hi_r <= bus.a;
            end else if (bus.op == OP_MTLO) begin
              lo_r <= bus.a;
            end
          end
        end
        BUSY: begin
          if (cancel_req) begin
            count      <= '0;
            busy_r     <= 1'b0;
            pend_valid <= 1'b0;
            state      <= IDLE;
          end else if (count == CNT_W'(1)) begin
            if (pend_valid) begin
              hi_r <= hi_p;
              lo_r <= lo_p;
            end
            count      <= '0;
            busy_r     <= 1'b0;
            pend_valid <= 1'b0;
            state      <= IDLE;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          count  <= '0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
  assign bus.md_stall = busy_r | (bus.start & is_md_op);

endmodule

// File: tb/tb_e_muldiv.sv
// tb_e_muldiv: directed bench for e_muldiv with an arithmetic reference
// model compared every cycle plus hand-computed literal checkpoints.
// Optional feature macro: MDU_CANCEL_EN (enables the cancel scenarios).
module tb_e_muldiv;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd7;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        cancel_eff;
`ifdef MDU_CANCEL_EN
  logic        cancel = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model state
  int          m_left;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [31:0] m_phi;
  logic [31:0] m_plo;
  bit          m_pvalid;
  longint      ps;
  longint      dq;
  longint      dr;
  longint unsigned pu;

  always #5 clk = ~clk;

  e_muldiv_if bus ();

  assign bus.start = start;
  assign bus.op    = op;
  assign bus.a     = a;
  assign bus.b     = b;
`ifdef MDU_CANCEL_EN
  assign bus.cancel = cancel;
  assign cancel_eff = cancel;
`else
  assign cancel_eff = 1'b0;
`endif

  e_muldiv #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd7;
  endtask

  // Count busy cycles until the unit goes idle, bounded.
  task automatic waitIdle(output int n);
    n = 0;
    @(negedge clk);
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("[TB] FAIL busy_timeout got %0d expected <40", n);
    end
  endtask

  // Reference model: architectural behaviour evaluated at each rising edge.
  always @(posedge clk) begin
    if (!reset) begin
      m_left = 0; m_hi = 0; m_lo = 0; m_pvalid = 0; m_phi = 0; m_plo = 0;
    end else if (m_left > 0) begin
      if (cancel_eff) begin
        m_left = 0; m_pvalid = 0;
      end else begin
        m_left--;
        if (m_left == 0 && m_pvalid) begin
          m_hi = m_phi; m_lo = m_plo;
        end
      end
    end else if (start && !cancel_eff) begin
      case (op)
        3'd0: begin
          ps = longint'($signed(a)) * longint'($signed(b));
          m_phi = ps[63:32]; m_plo = ps[31:0]; m_pvalid = 1; m_left = 5;
        end
        3'd1: begin
          pu = {32'h0, a} * {32'h0, b};
          m_phi = pu[63:32]; m_plo = pu[31:0]; m_pvalid = 1; m_left = 5;
        end
        3'd2: begin
          m_left = 10; m_pvalid = (b != 0);
          if (b != 0) begin
            dq = longint'($signed(a)) / longint'($signed(b));
            dr = longint'($signed(a)) % longint'($signed(b));
            m_plo = dq[31:0]; m_phi = dr[31:0];
          end
        end
        3'd3: begin
          m_left = 10; m_pvalid = (b != 0);
          if (b != 0) begin
            m_plo = a / b; m_phi = a % b;
          end
        end
        3'd4: m_hi = a;
        3'd5: m_lo = a;
        default: ;
      endcase
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("busy", {31'd0, bus.busy}, {31'd0, (m_left > 0)});
      checkOutput("md_stall", {31'd0, bus.md_stall}, {31'd0, ((m_left > 0) || (start && op < 3'd4))});
      checkOutput("hi", bus.hi, m_hi);
      checkOutput("lo", bus.lo, m_lo);
    end
  end

  initial begin
    int n;
    $display("[TB] e_muldiv bench start");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    checkOutput("reset_hi", bus.hi, 32'h0);
    checkOutput("reset_lo", bus.lo, 32'h0);
    checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);

    applyStimulus(3'd0, 32'hFFFFFFFF, 32'd2);
    waitIdle(n);
    checkOutput("mult_cycles", n, 32'd5);
    checkOutput("mult_hi", bus.hi, 32'hFFFFFFFF);
    checkOutput("mult_lo", bus.lo, 32'hFFFFFFFE);

    applyStimulus(3'd1, 32'hFFFFFFFF, 32'd2);
    waitIdle(n);
    checkOutput("multu_cycles", n, 32'd5);
    checkOutput("multu_hi", bus.hi, 32'h00000001);
    checkOutput("multu_lo", bus.lo, 32'hFFFFFFFE);

    applyStimulus(3'd2, 32'hFFFFFFF9, 32'd2);
    waitIdle(n);
    checkOutput("div_cycles", n, 32'd10);
    checkOutput("div_lo", bus.lo, 32'hFFFFFFFD);
    checkOutput("div_hi", bus.hi, 32'hFFFFFFFF);

    applyStimulus(3'd3, 32'd7, 32'd2);
    waitIdle(n);
    checkOutput("divu_lo", bus.lo, 32'd3);
    checkOutput("divu_hi", bus.hi, 32'd1);

    applyStimulus(3'd2, 32'h80000000, 32'hFFFFFFFF);
    waitIdle(n);
    checkOutput("div_ovf_lo", bus.lo, 32'h80000000);
    checkOutput("div_ovf_hi", bus.hi, 32'h0);

    applyStimulus(3'd4, 32'hAAAA0000, 32'd0);
    applyStimulus(3'd5, 32'h12345678, 32'd0);
    @(negedge clk);
    checkOutput("mtlo_lo", bus.lo, 32'h12345678);
    checkOutput("mtlo_hi", bus.hi, 32'hAAAA0000);
    checkOutput("mtlo_busy", {31'd0, bus.busy}, 32'd0);

    applyStimulus(3'd3, 32'd99, 32'd0);
    waitIdle(n);
    checkOutput("divu0_cycles", n, 32'd10);
    checkOutput("divu0_hi", bus.hi, 32'hAAAA0000);
    checkOutput("divu0_lo", bus.lo, 32'h12345678);

    // A second MULT issued while busy must be ignored.
    applyStimulus(3'd0, 32'd3, 32'd4);
    start = 1'b1; op = 3'd0; a = 32'd100; b = 32'd100;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd7;
    waitIdle(n);
    checkOutput("ignored_hi", bus.hi, 32'd0);
    checkOutput("ignored_lo", bus.lo, 32'd12);

    // Extra signed/unsigned corners checked through the model.
    applyStimulus(3'd0, 32'h7FFFFFFF, 32'h80000000);
    waitIdle(n);
    applyStimulus(3'd2, 32'hFFFFFFF9, 32'hFFFFFFFE);
    waitIdle(n);
    checkOutput("div_negneg_lo", bus.lo, 32'd3);
    checkOutput("div_negneg_hi", bus.hi, 32'hFFFFFFFF);
    applyStimulus(3'd3, 32'hFFFFFFF9, 32'd16);
    waitIdle(n);

`ifdef MDU_CANCEL_EN
    // Cancel during the third busy cycle of a MULT.
    applyStimulus(3'd1, 32'd1000, 32'd1000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    @(negedge clk);
    checkOutput("cancel_busy", {31'd0, bus.busy}, 32'd0);
    repeat (6) @(negedge clk);
    checkOutput("cancel_lo", bus.lo, 32'hFFFFFFF9 >> 4);
    // Cancel and start together in IDLE: nothing starts.
    @(posedge clk); #1;
    cancel = 1'b1; start = 1'b1; op = 3'd5; a = 32'hDEADBEEF;
    @(posedge clk); #1;
    cancel = 1'b0; start = 1'b0; op = 3'd7;
    @(negedge clk);
    checkOutput("cancel_mtlo_lo", bus.lo, 32'h0FFFFFFF);
    @(posedge clk); #1;
    cancel = 1'b1; start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5;
    @(posedge clk); #1;
    cancel = 1'b0; start = 1'b0; op = 3'd7;
    @(negedge clk);
    checkOutput("cancel_start_busy", {31'd0, bus.busy}, 32'd0);
`endif

    // Reset held low for two cycles in the middle of a DIV.
    applyStimulus(3'd2, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_hi", bus.hi, 32'h0);
    checkOutput("rst_mid_lo", bus.lo, 32'h0);
    checkOutput("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    repeat (15) @(negedge clk);
    checkOutput("rst_nocommit_lo", bus.lo, 32'h0);
    checkOutput("rst_nocommit_hi", bus.hi, 32'h0);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
